// File: rtl/uart_rx_frame.sv
// Mid-bit sampling receiver for an 11-bit UART frame (start, 8 data LSB first, parity, stop).
// state     | meaning
// IDLE      | line high, waiting for a start edge
// START     | confirming start bit at its midpoint
// DATA      | sampling 8 data bits plus parity
// STOP      | sampling stop bit, then publishing the frame
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_serial,
  output logic [10:0] packet_out,
  output logic [7:0]  data_out,
  output logic        valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic          sync1;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [9:0]    shreg;
  logic [10:0]   frame;

  // shreg fills from the top, so after start+data+parity the start bit sits at [0]
  assign frame    = {rxs, shreg};
  assign data_out = packet_out[8:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '1;
      packet_out <= 11'h7FF;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync1 <= rx_serial;
      rxs   <= sync1;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              shreg <= {rxs, shreg[9:1]};
              cnt   <= '0;
              idx   <= '0;
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[9:1]};
            if (idx == 4'd8) state <= STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt        <= '0;
            packet_out <= frame;
            valid      <= 1'b1;
            parity_err <= (^frame[9:1]) != PARITY_ODD;
            frame_err  <= ~rxs;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: vector table of whole frames plus corner-case sequences.
module tb_uart_rx_frame;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_serial;
  logic [10:0] packet_out;
  logic [7:0]  data_out;
  logic        valid, parity_err, frame_err, busy;

  uart_rx_frame #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial), .packet_out(packet_out),
    .data_out(data_out), .valid(valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [10:0] pkt;
    logic [7:0]  data;
    logic        pe;
    logic        fe;
  } rec_t;

  typedef struct {
    logic [7:0]  d;
    logic        p;
    logic        s;
    logic [10:0] pkt;
    logic        pe;
    logic        fe;
  } vec_t;

  rec_t q[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   total = 0;
  int   passed = 0;
  int   edge_cyc;

  always @(posedge clk) cyc++;

  // capture every valid pulse away from the active edge
  always @(negedge clk) begin
    if (valid) q.push_back('{cyc, packet_out, data_out, parity_err, frame_err});
    if (busy) busy_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    edge_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      rx_serial = f[i];
      repeat (N) @(negedge clk);
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 11'h54A, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 11'h402, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 11'h5FE, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 11'h700, 1'b0, 1'b0};
    vecs[4] = '{8'h0F, 1'b1, 1'b1, 11'h61E, 1'b1, 1'b0};

    rst = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_packet", 32'(packet_out), 32'h7FF);
    check("reset_data", 32'(data_out), 32'hFF);
    check("reset_valid", 32'(valid), 0);
    check("reset_perr", 32'(parity_err), 0);
    check("reset_ferr", 32'(frame_err), 0);
    check("reset_busy", 32'(busy), 0);

    for (int v = 0; v < 5; v++) begin
      q.delete();
      send_frame(vecs[v].d, vecs[v].p, vecs[v].s);
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_count", v), 32'(q.size()), 1);
      if (q.size() > 0) begin
        check($sformatf("vec%0d_latency", v), 32'(q[0].cyc - edge_cyc), 171);
        check($sformatf("vec%0d_packet", v), 32'(q[0].pkt), 32'(vecs[v].pkt));
        check($sformatf("vec%0d_data", v), 32'(q[0].data), 32'(vecs[v].d));
        check($sformatf("vec%0d_perr", v), 32'(q[0].pe), 32'(vecs[v].pe));
        check($sformatf("vec%0d_ferr", v), 32'(q[0].fe), 32'(vecs[v].fe));
      end
    end

    // stop bit low followed by a held-low break
    q.delete();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("break_count", 32'(q.size()), 1);
    if (q.size() > 0) begin
      check("break_ferr", 32'(q[0].fe), 1);
      check("break_perr", 32'(q[0].pe), 0);
      check("break_data", 32'(q[0].data), 32'h3C);
    end
    check("break_busy_held", 32'(busy), 1);
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    check("break_busy_released", 32'(busy), 0);
    q.delete();
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("after_break_count", 32'(q.size()), 1);
    if (q.size() > 0) begin
      check("after_break_packet", 32'(q[0].pkt), 32'h4AA);
      check("after_break_ferr", 32'(q[0].fe), 0);
    end

    // short low glitch must be rejected as a false start
    q.delete();
    busy_cnt = 0;
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_valid", 32'(q.size()), 0);
    check("glitch_busy_cycles", 32'(busy_cnt), 8);
    check("glitch_busy_end", 32'(busy), 0);
    check("glitch_packet_held", 32'(packet_out), 32'h4AA);

    // back-to-back frames with no idle gap
    q.delete();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_count", 32'(q.size()), 2);
    if (q.size() == 2) begin
      check("b2b_spacing", 32'(q[1].cyc - q[0].cyc), 176);
      check("b2b_data0", 32'(q[0].data), 32'h00);
      check("b2b_data1", 32'(q[1].data), 32'hFF);
      check("b2b_pkt1", 32'(q[1].pkt), 32'h5FE);
      check("b2b_flags", 32'({q[0].pe, q[0].fe, q[1].pe, q[1].fe}), 0);
    end

    // reset pulse in the middle of data bit 4
    q.delete();
    fork
      send_frame(8'h5A, 1'b0, 1'b1);
      begin
        repeat (88) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_packet", 32'(packet_out), 32'h7FF);
        check("midrst_data", 32'(data_out), 32'hFF);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_flags", 32'({valid, parity_err, frame_err}), 0);
      end
    join
    check("midrst_no_valid", 32'(q.size()), 0);
    // let any frame resynchronised on the aborted bits drain out
    repeat (250) @(negedge clk);
    q.delete();
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rst_count", 32'(q.size()), 1);
    if (q.size() > 0) begin
      check("post_rst_packet", 32'(q[0].pkt), 32'h4B4);
      check("post_rst_data", 32'(q[0].data), 32'h5A);
      check("post_rst_flags", 32'({q[0].pe, q[0].fe}), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
